// File: rtl/cpu7_csr_intc_pkg.sv
`default_nettype none
// cpu7_csr_intc_pkg: ESTAT.IS bit layout, scheduler state encoding and priority helper.
// Revision: 1.0
package cpu7_csr_intc_pkg;

  localparam int IS_W    = 13;
  localparam int IDX_W   = 4;
  localparam int IS_SWI0 = 0;
  localparam int IS_HWI0 = 2;
  localparam int IS_RSVD = 10;
  localparam int IS_TI   = 11;
  localparam int IS_IPI  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_TAKEN = 2'd2
  } intc_state_e;

  // Highest set bit wins; returns 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] prio_idx(input logic [IS_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < IS_W; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu7_csr_intc_sync.sv
`default_nettype none
// cpu7_csr_intc_sync: N-stage multi-bit synchroniser with asynchronous active-low reset.
// Revision: 1.0
module cpu7_csr_intc_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Fewer than two stages gives no metastability protection.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [WIDTH-1:0] sync_q [N];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < N; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[N-1];

endmodule
`default_nettype wire

// File: rtl/cpu7_csr_intc.sv
`default_nettype none
// cpu7_csr_intc: HWI sync/latch, ECFG.LIE mask, ESTAT.IS merge and request/ack scheduler.
// Revision: 1.0
module cpu7_csr_intc
  import cpu7_csr_intc_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] HWI_EDGE    = 8'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ecfg_wen,
  input  logic [12:0] ecfg_wdata,
  input  logic [12:0] ecfg_mask,
  output logic [12:0] ecfg_lie,
  input  logic [1:0]  swi,
  input  logic [7:0]  ext_intr,
  input  logic [7:0]  hwi_clr,
  input  logic        timer_intr,
  input  logic        ipi,
  input  logic        crmd_ie,
  input  logic        intr_ack,
  output logic        intr_req,
  output logic [3:0]  intr_idx,
  output logic [12:0] intr_pending
);

  localparam logic [IS_W-1:0] RSVD_MASK = IS_W'(1) << IS_RSVD;

  logic [7:0]      hwi_sync;
  logic [7:0]      hwi_prev_q;
  logic [7:0]      hwi_rise;
  logic [7:0]      hwi_latch_q, hwi_latch_d;
  logic [7:0]      hwi_view;
  logic [IS_W-1:0] lie_q, lie_d;
  logic [IS_W-1:0] pend;
  logic [IS_W-1:0] en;
  intc_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  cpu7_csr_intc_sync #(
    .WIDTH  (8),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (ext_intr),
    .q_o    (hwi_sync)
  );

  // The rise term is ORed into the view so edge bits show up with the same
  // latency as level bits, one cycle before the latch itself is set.
  assign hwi_rise    = hwi_sync & ~hwi_prev_q & HWI_EDGE;
  assign hwi_latch_d = (hwi_rise | (hwi_latch_q & ~hwi_clr)) & HWI_EDGE;
  assign hwi_view    = (hwi_sync & ~HWI_EDGE) | ((hwi_latch_q | hwi_rise) & HWI_EDGE);

  always_comb begin
    lie_d = lie_q;
    if (ecfg_wen) lie_d = (lie_q & ~ecfg_mask) | (ecfg_wdata & ecfg_mask);
    lie_d = lie_d & ~RSVD_MASK;
  end

  always_comb begin
    pend                 = '0;
    pend[IS_SWI0 +: 2]   = swi;
    pend[IS_HWI0 +: 8]   = hwi_view;
    pend[IS_TI]          = timer_intr;
    pend[IS_IPI]         = ipi;
  end

  assign en = pend & lie_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (crmd_ie && (|en)) begin
          state_d = ST_REQ;
          idx_d   = prio_idx(en);
        end
      end
      ST_REQ: begin
        if (intr_ack)                   state_d = ST_TAKEN;
        else if (!crmd_ie || !en[idx_q]) state_d = ST_IDLE;
      end
      ST_TAKEN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hwi_prev_q  <= '0;
      hwi_latch_q <= '0;
      lie_q       <= '0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
    end else begin
      hwi_prev_q  <= hwi_sync;
      hwi_latch_q <= hwi_latch_d;
      lie_q       <= lie_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
    end
  end

  assign ecfg_lie     = lie_q;
  assign intr_pending = pend;
  assign intr_req     = (state_q == ST_REQ);
  assign intr_idx     = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu7_csr_intc.sv
`default_nettype none
// tb_cpu7_csr_intc: directed scenarios plus randomized traffic against a cycle-level reference model.
// Revision: 1.0
module tb_cpu7_csr_intc;

  localparam int         S  = 2;
  localparam logic [7:0] HE = 8'hF0;  // HWI0-3 level, HWI4-7 edge

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ecfg_wen = 1'b0;
  logic [12:0] ecfg_wdata = '0, ecfg_mask = '0;
  logic [12:0] ecfg_lie;
  logic [1:0]  swi = '0;
  logic [7:0]  ext_intr = '0, hwi_clr = '0;
  logic        timer_intr = 1'b0, ipi = 1'b0, crmd_ie = 1'b0, intr_ack = 1'b0;
  logic        intr_req;
  logic [3:0]  intr_idx;
  logic [12:0] intr_pending;

  cpu7_csr_intc #(.SYNC_STAGES(S), .HWI_EDGE(HE)) dut (
    .clk(clk), .resetn(resetn), .ecfg_wen(ecfg_wen), .ecfg_wdata(ecfg_wdata),
    .ecfg_mask(ecfg_mask), .ecfg_lie(ecfg_lie), .swi(swi), .ext_intr(ext_intr),
    .hwi_clr(hwi_clr), .timer_intr(timer_intr), .ipi(ipi), .crmd_ie(crmd_ie),
    .intr_ack(intr_ack), .intr_req(intr_req), .intr_idx(intr_idx),
    .intr_pending(intr_pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: m_hist[k] is the pin vector sampled k+1 edges ago.
  logic [7:0]  m_hist [0:S];
  logic [7:0]  m_latch;
  logic [12:0] m_lie;
  int          m_mode;  // 0 idle, 1 requesting, 2 just taken
  logic [3:0]  m_idx;

  function automatic logic [12:0] m_pending();
    logic [7:0] synced, rise, hv;
    synced = m_hist[S-1];
    rise   = synced & ~m_hist[S] & HE;
    hv     = (synced & ~HE) | ((m_latch | rise) & HE);
    return {ipi, timer_intr, 1'b0, hv, swi};
  endfunction

  function automatic logic [3:0] m_top(input logic [12:0] v);
    for (int i = 12; i >= 0; i--) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic m_reset();
    for (int k = 0; k <= S; k++) m_hist[k] = '0;
    m_latch = '0; m_lie = '0; m_mode = 0; m_idx = '0;
  endtask

  task automatic m_clock();
    logic [12:0] en;
    logic [7:0]  rise;
    en   = m_pending() & m_lie;
    rise = m_hist[S-1] & ~m_hist[S] & HE;
    m_latch = (rise | (m_latch & ~hwi_clr)) & HE;
    for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = ext_intr;
    if (ecfg_wen) begin
      m_lie = (m_lie & ~ecfg_mask) | (ecfg_wdata & ecfg_mask);
      m_lie[10] = 1'b0;
    end
    case (m_mode)
      0: if (crmd_ie && en != 0) begin m_mode = 1; m_idx = m_top(en); end
      1: if (intr_ack) m_mode = 2; else if (!crmd_ie || !en[m_idx]) m_mode = 0;
      default: m_mode = 0;
    endcase
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (!resetn) m_reset(); else m_clock();
      #1;
    end
  endtask

  task automatic write_lie(input logic [12:0] d, input logic [12:0] m);
    ecfg_wen = 1'b1; ecfg_wdata = d; ecfg_mask = m;
    cyc();
    ecfg_wen = 1'b0; ecfg_wdata = '0; ecfg_mask = '0;
  endtask

  task automatic test_reset();
    m_reset();
    resetn = 1'b0; swi = 2'b01;
    cyc(2);
    total++; if (intr_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", intr_req); end
    total++; if (intr_idx !== 4'd0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", intr_idx); end
    total++; if (ecfg_lie !== 13'h0) begin bad++; $display("FAIL rst_lie got=%h exp=0000", ecfg_lie); end
    total++; if (intr_pending !== 13'h0001) begin bad++; $display("FAIL rst_pend got=%h exp=0001", intr_pending); end
    resetn = 1'b1; swi = 2'b00;
    cyc();
  endtask

  task automatic test_ecfg();
    write_lie(13'h1FFF, 13'h1FFF);
    total++; if (ecfg_lie !== 13'h1BFF) begin bad++; $display("FAIL lie_all got=%h exp=1bff", ecfg_lie); end
    write_lie(13'h0000, 13'h0800);
    total++; if (ecfg_lie !== 13'h13FF) begin bad++; $display("FAIL lie_mask got=%h exp=13ff", ecfg_lie); end
    write_lie(13'h1FFF, 13'h1FFF);
  endtask

  task automatic test_level_hwi();
    crmd_ie = 1'b1; ext_intr = 8'h01;
    cyc();
    total++; if (intr_pending[2] !== 1'b0) begin bad++; $display("FAIL lvl_c1 got=%0b exp=0", intr_pending[2]); end
    cyc();
    total++; if (intr_pending[2] !== 1'b1 || intr_req !== 1'b0) begin bad++; $display("FAIL lvl_c2 got=%0b/%0b exp=1/0", intr_pending[2], intr_req); end
    cyc();
    total++; if (intr_req !== 1'b1 || intr_idx !== 4'd2) begin bad++; $display("FAIL lvl_c3 got=%0b/%0d exp=1/2", intr_req, intr_idx); end
    cyc(2);
    total++; if (intr_req !== 1'b1 || intr_idx !== 4'd2) begin bad++; $display("FAIL lvl_c5 got=%0b/%0d exp=1/2", intr_req, intr_idx); end
    intr_ack = 1'b1;
    cyc();
    intr_ack = 1'b0;
    total++; if (intr_req !== 1'b0) begin bad++; $display("FAIL lvl_taken got=%0b exp=0", intr_req); end
    cyc();
    total++; if (intr_req !== 1'b0) begin bad++; $display("FAIL lvl_idle got=%0b exp=0", intr_req); end
    cyc();
    total++; if (intr_req !== 1'b1 || intr_idx !== 4'd2) begin bad++; $display("FAIL lvl_rereq got=%0b/%0d exp=1/2", intr_req, intr_idx); end
    ext_intr = 8'h00; crmd_ie = 1'b0;
    cyc(4);
  endtask

  task automatic test_priority();
    swi = 2'b11; timer_intr = 1'b1; ipi = 1'b1; crmd_ie = 1'b1;
    cyc();
    total++; if (intr_req !== 1'b1 || intr_idx !== 4'd12) begin bad++; $display("FAIL pri_ipi got=%0b/%0d exp=1/12", intr_req, intr_idx); end
    total++; if (intr_pending !== 13'h1803) begin bad++; $display("FAIL pri_pend got=%h exp=1803", intr_pending); end
    ipi = 1'b0; intr_ack = 1'b1;
    cyc();
    intr_ack = 1'b0;
    total++; if (intr_req !== 1'b0) begin bad++; $display("FAIL pri_taken got=%0b exp=0", intr_req); end
    cyc(2);
    total++; if (intr_req !== 1'b1 || intr_idx !== 4'd11) begin bad++; $display("FAIL pri_ti got=%0b/%0d exp=1/11", intr_req, intr_idx); end
    ipi = 1'b1;
    cyc();
    total++; if (intr_req !== 1'b1 || intr_idx !== 4'd11) begin bad++; $display("FAIL pri_frozen got=%0b/%0d exp=1/11", intr_req, intr_idx); end
    ipi = 1'b0; crmd_ie = 1'b0;
    cyc();
    total++; if (intr_req !== 1'b0) begin bad++; $display("FAIL pri_withdraw got=%0b exp=0", intr_req); end
    intr_ack = 1'b1;
    cyc();
    intr_ack = 1'b0; crmd_ie = 1'b1;
    total++; if (intr_req !== 1'b0) begin bad++; $display("FAIL pri_ack_idle got=%0b exp=0", intr_req); end
    cyc();
    total++; if (intr_req !== 1'b1 || intr_idx !== 4'd11) begin bad++; $display("FAIL pri_from_idle got=%0b/%0d exp=1/11", intr_req, intr_idx); end
    swi = 2'b00; timer_intr = 1'b0; crmd_ie = 1'b0;
    cyc(3);
  endtask

  task automatic test_edge_hwi();
    ext_intr = 8'h10;
    cyc(2);
    total++; if (intr_pending[6] !== 1'b1) begin bad++; $display("FAIL edge_rise got=%0b exp=1", intr_pending[6]); end
    cyc();
    ext_intr = 8'h00;
    cyc(4);
    total++; if (intr_pending[6] !== 1'b1) begin bad++; $display("FAIL edge_sticky got=%0b exp=1", intr_pending[6]); end
    ext_intr = 8'h10;
    cyc(2);
    hwi_clr = 8'h10;
    cyc();
    hwi_clr = 8'h00;
    total++; if (intr_pending[6] !== 1'b1) begin bad++; $display("FAIL edge_set_wins got=%0b exp=1", intr_pending[6]); end
    ext_intr = 8'h00;
    cyc(3);
    total++; if (intr_pending[6] !== 1'b1) begin bad++; $display("FAIL edge_hold got=%0b exp=1", intr_pending[6]); end
    hwi_clr = 8'h10;
    cyc();
    hwi_clr = 8'h00;
    total++; if (intr_pending[6] !== 1'b0) begin bad++; $display("FAIL edge_clr got=%0b exp=0", intr_pending[6]); end
    cyc();
    total++; if (intr_pending !== m_pending()) begin bad++; $display("FAIL edge_model got=%h exp=%h", intr_pending, m_pending()); end
  endtask

  task automatic test_async_reset();
    timer_intr = 1'b1; crmd_ie = 1'b1;
    cyc();
    total++; if (intr_req !== 1'b1 || intr_idx !== 4'd11) begin bad++; $display("FAIL ar_pre got=%0b/%0d exp=1/11", intr_req, intr_idx); end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    m_reset();
    total++; if (intr_req !== 1'b0 || intr_idx !== 4'd0) begin bad++; $display("FAIL ar_drop got=%0b/%0d exp=0/0", intr_req, intr_idx); end
    total++; if (ecfg_lie !== 13'h0 || intr_pending !== 13'h0800) begin bad++; $display("FAIL ar_state got=%h/%h exp=0000/0800", ecfg_lie, intr_pending); end
    cyc(2);
    @(negedge clk);
    resetn = 1'b1;
    cyc();
    total++; if (intr_req !== 1'b0 || ecfg_lie !== 13'h0) begin bad++; $display("FAIL ar_release got=%0b/%h exp=0/0000", intr_req, ecfg_lie); end
    write_lie(13'h0800, 13'h1FFF);
    cyc();
    total++; if (intr_req !== 1'b1 || intr_idx !== 4'd11) begin bad++; $display("FAIL ar_rereq got=%0b/%0d exp=1/11", intr_req, intr_idx); end
    timer_intr = 1'b0; crmd_ie = 1'b0;
    cyc(3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(7) == 0) ext_intr = ext_intr ^ 8'(1 << $urandom_range(7));
      swi        = ($urandom_range(9) == 0) ? 2'($urandom) : swi;
      timer_intr = ($urandom_range(11) == 0) ? ~timer_intr : timer_intr;
      ipi        = ($urandom_range(15) == 0) ? ~ipi : ipi;
      hwi_clr    = ($urandom_range(5) == 0) ? 8'($urandom) : 8'h00;
      crmd_ie    = ($urandom_range(7) != 0);
      intr_ack   = ($urandom_range(3) == 0);
      ecfg_wen   = ($urandom_range(9) == 0);
      ecfg_wdata = 13'($urandom);
      ecfg_mask  = 13'($urandom);
      cyc();
      total++; if (intr_req !== (m_mode == 1)) begin bad++; $display("FAIL rnd_req n=%0d got=%0b exp=%0b", n, intr_req, (m_mode == 1)); end
      total++; if (intr_idx !== m_idx) begin bad++; $display("FAIL rnd_idx n=%0d got=%0d exp=%0d", n, intr_idx, m_idx); end
      total++; if (ecfg_lie !== m_lie) begin bad++; $display("FAIL rnd_lie n=%0d got=%h exp=%h", n, ecfg_lie, m_lie); end
      total++; if (intr_pending !== m_pending()) begin bad++; $display("FAIL rnd_pend n=%0d got=%h exp=%h", n, intr_pending, m_pending()); end
    end
    ecfg_wen = 1'b0; intr_ack = 1'b0; hwi_clr = 8'h00;
  endtask

  initial begin
    test_reset();
    test_ecfg();
    test_level_hwi();
    test_priority();
    test_edge_hwi();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
